// File: rtl/dna_pkg.sv
// Shared constants and FSM state type for the device-DNA read arbiter.
package dna_pkg;

  localparam int unsigned DNA_WIDTH = 57;
  localparam int unsigned DNA_CNT_W = 6;
  localparam logic [DNA_WIDTH-1:0] SIM_DNA_DEFAULT = 57'h028340E18D8C85C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FINISH
  } dna_state_t;

endpackage

// File: rtl/dna_port_wrap.sv
// Isolates the device DNA_PORT so the sequencer stays vendor-neutral.
// Behavioural equivalent: READ parallel-loads, SHIFT moves left with DIN at LSB, DOUT is MSB.
module dna_port_wrap
  import dna_pkg::*;
#(
  parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = SIM_DNA_DEFAULT
) (
  input  logic clk,
  input  logic read,
  input  logic shift,
  input  logic din,
  output logic dout
);

  logic [DNA_WIDTH-1:0] r_dna;

  // The primitive has no reset; the arbiter always issues READ before SHIFT.
  always_ff @(posedge clk) begin
    if (read)
      r_dna <= SIM_DNA_VALUE;
    else if (shift)
      r_dna <= {r_dna[DNA_WIDTH-2:0], din};
  end

  assign dout = r_dna[DNA_WIDTH-1];

endmodule

// File: rtl/dna_read_arbiter.sv
// Sole sequencer of the DNA port: one automatic read after reset, then round-robin
// service of requesters, each pass comparing the captured DNA with the latched expectation.
module dna_read_arbiter
  import dna_pkg::*;
#(
  parameter int unsigned          NUM_REQ       = 4,
  parameter bit                   AUTO_READ     = 1'b1,
  parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = SIM_DNA_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DNA_WIDTH-1:0]   req_expected,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           done,
  output logic [2:0]                     done_id,
  output logic                           done_auto,
  output logic                           match,
  output logic [DNA_WIDTH-1:0]           dna_value,
  output logic                           dna_valid,
  output logic                           busy
);

  dna_state_t           r_state, w_next;
  logic                 r_auto_pending;
  logic                 r_auto;
  logic [2:0]           r_rr;
  logic [2:0]           r_id;
  logic [DNA_WIDTH-1:0] r_exp;
  logic [DNA_WIDTH-1:0] r_shift;
  logic [DNA_CNT_W-1:0] r_cnt;
  logic [DNA_WIDTH-1:0] r_dna;
  logic                 r_dna_valid;

  logic                 w_read, w_shift, w_dout;
  logic [3:0]           w_pick;
  logic [DNA_WIDTH-1:0] w_exp_arr [8];

  // First requesting index at or after ptr, wrapping; bit 3 flags that one was found.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 3'((32'(ptr) + k) % NUM_REQ);
      if (!res[3] && r[idx])
        res = {1'b1, idx};
    end
    return res;
  endfunction

  for (genvar g = 0; g < 8; g++) begin : g_exp
    if (g < NUM_REQ) begin : g_used
      assign w_exp_arr[g] = req_expected[DNA_WIDTH*g +: DNA_WIDTH];
    end else begin : g_pad
      assign w_exp_arr[g] = '0;
    end
  end

  assign w_pick = rr_pick(8'(req), r_rr);

  always_comb begin
    w_next    = r_state;
    w_read    = 1'b0;
    w_shift   = 1'b0;
    gnt       = '0;
    done      = 1'b0;
    done_id   = '0;
    done_auto = 1'b0;
    match     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_auto_pending) begin
          w_next = S_LOAD;
        end else if (w_pick[3]) begin
          gnt    = NUM_REQ'(1) << w_pick[2:0];
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_read = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == DNA_CNT_W'(DNA_WIDTH - 1))
          w_next = S_FINISH;
      end
      S_FINISH: begin
        done      = 1'b1;
        done_id   = r_id;
        done_auto = r_auto;
        match     = !r_auto && (r_dna == r_exp);
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_auto_pending <= AUTO_READ;
      r_auto         <= 1'b0;
      r_rr           <= '0;
      r_id           <= '0;
      r_exp          <= '0;
      r_shift        <= '0;
      r_cnt          <= '0;
      r_dna          <= '0;
      r_dna_valid    <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (r_auto_pending) begin
            r_auto_pending <= 1'b0;
            r_auto         <= 1'b1;
            r_id           <= '0;
          end else if (w_pick[3]) begin
            r_auto <= 1'b0;
            r_id   <= w_pick[2:0];
            r_exp  <= w_exp_arr[w_pick[2:0]];
          end
        end
        S_LOAD: r_cnt <= '0;
        S_SHIFT: begin
          r_shift <= {r_shift[DNA_WIDTH-2:0], w_dout};
          r_cnt   <= r_cnt + 1'b1;
          // Publish on the last sample so dna_value is already valid alongside done.
          if (r_cnt == DNA_CNT_W'(DNA_WIDTH - 1)) begin
            r_dna       <= {r_shift[DNA_WIDTH-2:0], w_dout};
            r_dna_valid <= 1'b1;
          end
        end
        S_FINISH: begin
          if (!r_auto)
            r_rr <= (r_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign dna_value = r_dna;
  assign dna_valid = r_dna_valid;
  assign busy      = (r_state != S_IDLE);

  dna_port_wrap #(
    .SIM_DNA_VALUE(SIM_DNA_VALUE)
  ) u_dna_port (
    .clk  (clk),
    .read (w_read),
    .shift(w_shift),
    .din  (1'b0),
    .dout (w_dout)
  );

endmodule
